// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay model: contact state names,
// default counter width and the delay-fits-in-counter check.
package relay_pkg;

    localparam int unsigned RELAY_CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        OPEN         = 2'd0,
        PULLING_IN   = 2'd1,
        CLOSED       = 2'd2,
        DROPPING_OUT = 2'd3
    } relay_state_e;

    // True when a delay of d cycles can be counted by a w-bit counter.
    function automatic bit delay_fits(input int unsigned d, input int unsigned w);
        longint unsigned limit;
        limit = (64'(1) << w) - 64'(1);
        return 64'(d) <= limit;
    endfunction

endpackage

// File: rtl/relay_delay_ctr.sv
// Qualifies "target consecutive active cycles": counts while active, fires done_c
// on the target-th active edge (immediately when target is 0) and restarts on any gap.
module relay_delay_ctr #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic [CNT_W-1:0] target,
    output logic             done_c,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned EXT_W = CNT_W + 1;

    logic [EXT_W-1:0] cnt_inc;

    // One bit wider so the increment of an all-ones count cannot alias a small target.
    assign cnt_inc = EXT_W'(cnt) + EXT_W'(1);
    assign done_c  = active & ((target == '0) | (cnt_inc == EXT_W'(target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || done_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/our_relay.sv
// Single-pole relay: coil = switch & batt drives the normally-open contact,
// with optional pull-in / drop-out delays counted in clock cycles.
module our_relay
    import relay_pkg::*;
#(
    parameter int unsigned PULL_IN  = 0,
    parameter int unsigned DROP_OUT = 0,
    parameter int unsigned CNT_W    = RELAY_CNT_W_DEFAULT
) (
    output logic out,
    input  logic switch,
    input  logic batt,
    input  logic clk,
    input  logic rst_n,
    output logic out_nc,
    output logic settling
);

    if (!delay_fits(PULL_IN, CNT_W) || !delay_fits(DROP_OUT, CNT_W)) begin : g_bad_delay
        $error("our_relay: PULL_IN/DROP_OUT exceed the CNT_W counter range");
    end

    logic             coil;
    logic             closed_q;
    logic             flip_c;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt;
    relay_state_e     state_c;

    assign coil = switch & batt;

    // One counter serves both directions: it runs whenever coil disagrees with the contact.
    assign target = closed_q ? CNT_W'(DROP_OUT) : CNT_W'(PULL_IN);

    relay_delay_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (coil ^ closed_q),
        .target (target),
        .done_c (flip_c),
        .cnt    (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            closed_q <= 1'b0;
        end else if (flip_c) begin
            closed_q <= ~closed_q;
        end
    end

    always_comb begin
        state_c = OPEN;
        if (closed_q) begin
            state_c = (cnt != '0) ? DROPPING_OUT : CLOSED;
        end else begin
            state_c = (cnt != '0) ? PULLING_IN : OPEN;
        end
    end

    // A zero delay in a direction lets coil pass straight through to the contact.
    always_comb begin
        out = 1'b0;
        if (rst_n) begin
            if (closed_q) begin
                out = (DROP_OUT == 0) ? coil : 1'b1;
            end else begin
                out = (PULL_IN == 0) ? coil : 1'b0;
            end
        end
    end

    assign out_nc   = ~out;
    assign settling = (state_c == PULLING_IN) || (state_c == DROPPING_OUT);

endmodule

// File: tb/tb_our_relay.sv
// Bench for our_relay: zero-delay, paired and delayed instances checked against
// a sample-history model of the relay's consecutive-edge rules.
module tb_our_relay;

    localparam int unsigned D_PI = 3;
    localparam int unsigned D_DO = 2;
    localparam int unsigned R_PI = 1;
    localparam int unsigned R_DO = 4;
    localparam int unsigned HIST = 4096;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_z, bt_z, sw_a, sw_b, sw_d, bt_d, sw_r, bt_r;
    logic out_z, nc_z, st_z, out_a, nc_a, st_a, out_b, nc_b, st_b;
    logic out_d, nc_d, st_d, out_r, nc_r, st_r;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    our_relay u_z (.out(out_z), .switch(sw_z), .batt(bt_z), .clk(clk), .rst_n(rst_n),
                   .out_nc(nc_z), .settling(st_z));
    our_relay u_a (.out(out_a), .switch(sw_a), .batt(1'b1), .clk(clk), .rst_n(rst_n),
                   .out_nc(nc_a), .settling(st_a));
    our_relay u_b (.out(out_b), .switch(sw_b), .batt(1'b1), .clk(clk), .rst_n(rst_n),
                   .out_nc(nc_b), .settling(st_b));
    our_relay #(.PULL_IN(D_PI), .DROP_OUT(D_DO)) u_d (.out(out_d), .switch(sw_d), .batt(bt_d),
                   .clk(clk), .rst_n(rst_n), .out_nc(nc_d), .settling(st_d));
    our_relay #(.PULL_IN(R_PI), .DROP_OUT(R_DO)) u_r (.out(out_r), .switch(sw_r), .batt(bt_r),
                   .clk(clk), .rst_n(rst_n), .out_nc(nc_r), .settling(st_r));

    // Model: coil samples per edge; the contact flips once the last N samples since
    // its previous change all show the opposite level.
    bit hist [2][HIST];
    int last_chg [2];
    bit m_closed [2];
    int dly_in [2];
    int dly_out [2];
    int e_idx = 0;

    function automatic int trail(input int i);
        int n = 0;
        for (int k = e_idx; k > last_chg[i]; k--) begin
            if (hist[i][k] != m_closed[i]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_edge(input bit c0, input bit c1);
        e_idx++;
        hist[0][e_idx] = c0;
        hist[1][e_idx] = c1;
        for (int i = 0; i < 2; i++) begin
            if (trail(i) >= (m_closed[i] ? dly_out[i] : dly_in[i])) begin
                m_closed[i] = !m_closed[i];
                last_chg[i] = e_idx;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_closed[i] = 1'b0;
            last_chg[i] = e_idx;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_delayed();
        chk("d_out", out_d, m_closed[0] & rst_n);
        chk("d_nc", nc_d, ~(m_closed[0] & rst_n));
        chk("d_settling", st_d, trail(0) != 0);
        chk("r_out", out_r, m_closed[1] & rst_n);
        chk("r_settling", st_r, trail(1) != 0);
    endtask

    // Advance one rising edge, feed the model the coil seen at that edge, then check.
    task automatic tick();
        @(posedge clk);
        if (e_idx >= HIST - 2) begin
            $display("FAIL history_bound: observed %0d expected < %0d", e_idx, HIST - 2);
            $fatal(1, "history exhausted");
        end
        if (rst_n) model_edge(sw_d & bt_d, sw_r & bt_r);
        #1;
        chk_delayed();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        bit [1:0] zv;
        dly_in[0] = D_PI; dly_out[0] = D_DO;
        dly_in[1] = R_PI; dly_out[1] = R_DO;
        model_reset();

        // Reset holds everything open even with coils energised.
        rst_n = 1'b0;
        sw_z = 1; bt_z = 1; sw_a = 1; sw_b = 1; sw_d = 1; bt_d = 1; sw_r = 1; bt_r = 1;
        #12;
        chk("rst_z_out", out_z, 1'b0);
        chk("rst_z_nc", nc_z, 1'b1);
        chk("rst_d_out", out_d, 1'b0);
        chk("rst_d_nc", nc_d, 1'b1);
        chk("rst_d_settling", st_d, 1'b0);
        chk("rst_r_out", out_r, 1'b0);
        sw_z = 0; bt_z = 0; sw_a = 0; sw_b = 0; sw_d = 0; bt_d = 0; sw_r = 0; bt_r = 0;
        #3 rst_n = 1'b1;
        model_reset();

        // Zero-delay truth table and AND of a parallel pair, 10 ns apart.
        for (int v = 0; v < 4; v++) begin
            zv = 2'(v);
            sw_z = zv[0]; bt_z = zv[1];
            sw_a = zv[0]; sw_b = zv[1];
            #10;
            chk("zero_out", out_z, zv[0] & zv[1]);
            chk("zero_nc", nc_z, ~(zv[0] & zv[1]));
            chk("zero_settling", st_z, 1'b0);
            chk("pair_and", out_a & out_b, zv[0] & zv[1]);
        end

        // Pull-in 3 then drop-out 2.
        @(posedge clk); #1;
        sw_d = 1; bt_d = 1;
        tick(); chk("pi_e1_out", out_d, 1'b0); chk("pi_e1_settling", st_d, 1'b1);
        tick(); chk("pi_e2_out", out_d, 1'b0); chk("pi_e2_settling", st_d, 1'b1);
        tick(); chk("pi_e3_out", out_d, 1'b1); chk("pi_e3_settling", st_d, 1'b0);
        sw_d = 0;
        tick(); chk("do_e1_out", out_d, 1'b1); chk("do_e1_settling", st_d, 1'b1);
        tick(); chk("do_e2_out", out_d, 1'b0);

        // Glitch of 2 edges is rejected.
        sw_d = 1;
        ticks(2);
        sw_d = 0;
        tick(); chk("glitch_out", out_d, 1'b0); chk("glitch_settling", st_d, 1'b0);

        // Asynchronous reset mid-operation, then a full pull-in again.
        sw_d = 1;
        ticks(3);
        chk("pre_rst_out", out_d, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out", out_d, 1'b0);
        chk("async_rst_nc", nc_d, 1'b1);
        rst_n = 1'b1;
        model_reset();
        ticks(2); chk("post_rst_e2_out", out_d, 1'b0);
        tick();   chk("post_rst_e3_out", out_d, 1'b1);
        sw_d = 0;
        ticks(2);

        // Drop-out 4 restarted by a one-edge re-energise.
        sw_r = 1; bt_r = 1;
        tick(); chk("r_close", out_r, 1'b1);
        sw_r = 0; ticks(3); chk("r_low3_out", out_r, 1'b1);
        sw_r = 1; tick();   chk("r_reen_out", out_r, 1'b1); chk("r_reen_settling", st_r, 1'b0);
        sw_r = 0; ticks(3); chk("r_relow3_out", out_r, 1'b1);
        tick();             chk("r_relow4_out", out_r, 1'b0);

        // Random runs: inputs toggle rarely so delays are regularly met and missed.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(3) == 0) sw_d = ~sw_d;
            if ($urandom_range(5) == 0) bt_d = ~bt_d;
            if ($urandom_range(3) == 0) sw_r = ~sw_r;
            if ($urandom_range(7) == 0) bt_r = ~bt_r;
            sw_z = 1'($urandom); bt_z = 1'($urandom);
            sw_a = 1'($urandom); sw_b = 1'($urandom);
            tick();
            chk("rnd_zero_out", out_z, sw_z & bt_z);
            chk("rnd_pair_and", out_a & out_b, sw_a & sw_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/our_relay.md
Name: our_relay

Overview:
- Behavioural model of a single-pole electromechanical relay, used as the basic switching element in the relay-logic circuits.
- The coil is energised when the control input `switch` and the supply input `batt` are both high.
- The normally-open contact drives `out`, with optional pull-in and drop-out delays counted in clock cycles.
- With both delays at 0 the block is purely combinational: `out = switch & batt`. Series and parallel relay networks are built by combining several instances' outputs externally.

Parameters:
- PULL_IN, default 0: consecutive energised clock cycles needed before the contact closes. 0 means the contact closes immediately (combinationally).
- DROP_OUT, default 0: consecutive de-energised clock cycles needed before the contact opens. 0 means the contact opens immediately (combinationally).
- CNT_W, default 8: width of the internal delay counter. Both delays must be ≤ 2^CNT_W − 1 (elaboration-time assertion).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- out  output  1  normally-open contact (first positional port).
- switch  input  1  control input (second positional port).
- batt  input  1  supply input (third positional port).
- out_nc  output  1  normally-closed contact, always `~out`.
- settling  output  1  high while a pull-in or drop-out count is in progress.

Behaviour:
- One clock; reset is asynchronous and active-low (ports `clk`, `rst_n`).
- Positional order is out, switch, batt, clk, rst_n, out_nc, settling, so that 3-port positional instantiation maps correctly. `clk` and `rst_n` must then be connected by name or tied off (`rst_n = 1`).
- coil = switch & batt.
- State: `closed_q` (contact latched closed) and `cnt` (CNT_W bits).
- Reset (rst_n = 0, asynchronous):
  - `closed_q = 0`, `cnt = 0`.
  - `out = 0`, `out_nc = 1`, `settling = 0`, regardless of coil.
- Pull-in (while `closed_q = 0`, on each rising clk edge):
  - If coil = 1: `cnt` increments. When `cnt + 1 == PULL_IN`, set `closed_q = 1` and clear `cnt`.
  - If coil = 0: clear `cnt`.
- Drop-out (while `closed_q = 1`, on each rising clk edge):
  - If coil = 0: `cnt` increments. When `cnt + 1 == DROP_OUT`, set `closed_q = 0` and clear `cnt`.
  - If coil = 1: clear `cnt`.
- A glitch shorter than the delay never changes the contact. Re-energising during drop-out, or de-energising during pull-in, restarts from 0.
- Output when reset is deasserted:
  - `closed_q = 0`: `out = (PULL_IN == 0) ? coil : 0`.
  - `closed_q = 1`: `out = (DROP_OUT == 0) ? coil : 1`.
- When a delay is 0, that direction's register update also follows coil on each clock, so `closed_q` stays consistent with `out`.
- `settling = (cnt != 0)`.
- With PULL_IN = DROP_OUT = 0: `out = coil & rst_n`, with no clock dependence and zero latency.
- Nonzero delay latency:
  - `out` rises on the PULL_IN-th consecutive rising edge at which coil = 1.
  - `out` falls on the DROP_OUT-th consecutive edge at which coil = 0.
- Counter saturation cannot occur, because the parameters are bounded.
- Reset mid-count: counter discarded, contact open. After release, a full pull-in delay is required again.
- X on switch or batt propagates to `out` in zero-delay mode. No X-masking is performed.

Decomposition:
- Shared package `relay_pkg`: holds the `relay_state_e` enum (OPEN, PULLING_IN, CLOSED, DROPPING_OUT), the `RELAY_CNT_W_DEFAULT` constant, and the bound-check function.
- One natural sub-module, `relay_delay_ctr`: a generic "N consecutive cycles of level L" qualifier, instantiated once and shared by both directions.
- Top-level logic: coil gating and output mux.

Test Plan:
- Zero-delay truth table: rst_n = 1, (switch, batt) stepped through 00, 10, 01, 11, 10 ns apart → `out` = 0, 0, 0, 1 and `out_nc` = 1, 1, 1, 0, with no clock toggling.
- Parallel pair, zero delay: two instances with batt = 1, combined by AND, switches 00/10/01/11 → combined output 0, 0, 0, 1.
- PULL_IN = 3, DROP_OUT = 2:
  - switch = batt = 1 from edge 0 → `out` = 1 after the 3rd rising edge, `settling` = 1 on edges 1–2.
  - switch to 0 → `out` = 0 after the 2nd edge.
- Glitch rejection, PULL_IN = 3: coil high for 2 edges then low → `out` stays 0 and `cnt` returns to 0 (`settling` = 0).
- Reset mid-operation, PULL_IN = 3: closed relay, then rst_n pulsed low between edges → `out` = 0 immediately (asynchronous). After release with coil = 1, `out` returns to 1 only after 3 more edges.
- Drop-out restart, DROP_OUT = 4: coil low for 3 edges, high for 1, low again → `out` stays 1 until 4 further consecutive low edges have elapsed.
